// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and helpers for the memory read-channel arbiter.
package mem_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Ceiling log2 for elaboration-time constants.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // AXI arsize encoding for a full-width beat of data_width bits.
    function automatic logic [2:0] arsize_for(input int data_width);
        return 3'(clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/mem_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr.
module rr_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest position back to ptr so the nearest request wins.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                grant_idx = idx;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin sharing of one AXI4 read channel between NUM_REQ masters,
// one whole burst per grant.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 8
) (
    input  logic                          aclk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            s_arvalid,
    output logic [NUM_REQ-1:0]            s_arready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_REQ*8-1:0]          s_arlen,
    output logic [NUM_REQ-1:0]            s_rvalid,
    input  logic [NUM_REQ-1:0]            s_rready,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic [ID_WIDTH-1:0]           m_arid,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic [ID_WIDTH-1:0]           m_rid
);

    localparam int         IDX_W  = clog2(NUM_REQ);
    localparam logic [2:0] ARSIZE = arsize_for(DATA_WIDTH);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             last_beat;
    logic             unused_rid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (s_arvalid),
        .ptr       (rr_ptr),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    // Routing follows the grant, not m_rid; the ID only mirrors the grant.
    assign unused_rid = ^m_rid;

    assign last_beat = m_rvalid & m_rready & m_rlast;

    assign m_araddr  = s_araddr[grant*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_arlen   = s_arlen[grant*8 +: 8];
    assign m_arsize  = ARSIZE;
    assign m_arburst = AXI_BURST_INCR;
    assign m_arid    = ID_WIDTH'(grant);

    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;
    assign s_rlast = m_rlast;

    // FSM state register.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the winner on arbitration; advance priority past it once its burst ends.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            if (state == ST_IDLE && pick_vld) begin
                grant <= pick_idx;
            end
            if (state == ST_DATA && last_beat) begin
                rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    // Next-state logic and per-state handshake steering.
    always_comb begin
        state_nxt = state;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        s_arready = '0;
        s_rvalid  = '0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_arvalid        = 1'b1;
                s_arready[grant] = m_arready;
                if (m_arready) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                s_rvalid[grant] = m_rvalid;
                m_rready        = s_rready[grant];
                if (m_rvalid && s_rready[grant] && m_rlast) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed/randomized bench for mem_read_arbiter acting as both requesters and memory.
module tb_mem_read_arbiter;

    localparam int N  = 2;
    localparam int AW = 24;
    localparam int DW = 64;
    localparam int IW = 8;

    logic            aclk;
    logic            resetn;
    logic [N-1:0]    s_arvalid;
    logic [N-1:0]    s_arready;
    logic [N*AW-1:0] s_araddr;
    logic [N*8-1:0]  s_arlen;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic            m_arvalid;
    logic            m_arready;
    logic [AW-1:0]   m_araddr;
    logic [7:0]      m_arlen;
    logic [2:0]      m_arsize;
    logic [1:0]      m_arburst;
    logic [IW-1:0]   m_arid;
    logic            m_rvalid;
    logic            m_rready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic [IW-1:0]   m_rid;

    logic [AW-1:0]   addr_m [N];
    logic [7:0]      len_m  [N];
    int              ptr_m;
    int              n_checks;
    int              n_pass;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign s_araddr[g*AW +: AW] = addr_m[g];
        assign s_arlen[g*8 +: 8]    = len_m[g];
    end

    mem_read_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW)
    ) dut (
        .aclk      (aclk),
        .resetn    (resetn),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_arid    (m_arid),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .m_rid     (m_rid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_m_arvalid"}, m_arvalid, 0);
        chk({tag, "_m_rready"},  m_rready,  0);
        chk({tag, "_s_arready"}, s_arready, 0);
        chk({tag, "_s_rvalid"},  s_rvalid,  0);
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        s_arvalid = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_rresp   = 2'b00;
        m_rdata   = '0;
        m_rid     = '0;
        repeat (2) @(posedge aclk);
        #1;
        check_quiet("reset");
        resetn = 1'b1;
        ptr_m  = 0;
        tick();
    endtask

    // One full burst, entered in IDLE with requests already presented.
    task automatic do_burst(input int delay, input bit toggle, input bit keep,
                            input int fixed_len, input logic [1:0] resp);
        int            exp;
        int            beats;
        int            guard;
        bit            acc;
        logic [AW-1:0] e_addr;
        logic [7:0]    e_len;
        // Next in rotation starting from the requester after the last one served.
        exp = -1;
        for (int k = 0; k < N; k++) begin
            if (exp < 0 && s_arvalid[(ptr_m + k) % N]) exp = (ptr_m + k) % N;
        end
        if (exp < 0) exp = 0;
        e_addr = addr_m[exp];
        e_len  = len_m[exp];
        #1;
        chk("idle_m_arvalid", m_arvalid, 0);
        chk("idle_m_rready", m_rready, 0);
        tick();
        for (int d = 0; d <= delay; d++) begin
            m_arready = (d == delay);
            #1;
            chk("ar_valid", m_arvalid, 1);
            chk("ar_addr", m_araddr, e_addr);
            chk("ar_len", m_arlen, e_len);
            chk("ar_id", m_arid, exp);
            chk("ar_size", m_arsize, 3);
            chk("ar_burst", m_arburst, 1);
            chk("s_arready", s_arready, m_arready ? (64'd1 << exp) : 64'd0);
            tick();
        end
        m_arready = 1'b0;
        if (keep) begin
            addr_m[exp] = AW'($urandom) & 24'hFFFFF8;
            len_m[exp]  = (fixed_len >= 0) ? 8'(fixed_len) : 8'($urandom_range(0, 3));
        end else begin
            s_arvalid[exp] = 1'b0;
        end
        beats    = 0;
        guard    = 0;
        m_rid    = IW'(exp);
        m_rvalid = 1'b1;
        m_rresp  = resp;
        m_rdata  = {$urandom, $urandom};
        m_rlast  = (e_len == 0);
        while (beats <= int'(e_len) && guard < 4 * (int'(e_len) + 2)) begin
            s_rready      = N'($urandom);
            s_rready[exp] = toggle ? guard[0] : 1'b1;
            #1;
            chk("data_m_arvalid", m_arvalid, 0);
            chk("s_rvalid", s_rvalid, 64'd1 << exp);
            chk("m_rready", m_rready, s_rready[exp]);
            chk("s_rdata", s_rdata, m_rdata);
            chk("s_rresp", s_rresp, resp);
            chk("s_rlast", s_rlast, (beats == int'(e_len)) ? 1 : 0);
            acc = s_rvalid[exp] & s_rready[exp];
            tick();
            guard++;
            if (acc) begin
                beats++;
                m_rdata = {$urandom, $urandom};
                m_rlast = (beats == int'(e_len));
            end
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = '0;
        chk("beat_count", beats, int'(e_len) + 1);
        ptr_m = (exp + 1) % N;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < N; i++) begin
            addr_m[i] = '0;
            len_m[i]  = '0;
        end

        // Reset state.
        do_reset();

        // Single request from requester 0.
        addr_m[0] = 24'h000100;
        len_m[0]  = 8'd3;
        addr_m[1] = 24'h0A0A00;
        len_m[1]  = 8'd1;
        s_arvalid = 2'b01;
        do_burst(0, 1'b0, 1'b0, -1, 2'b00);

        // Stray R beats while idle must not be accepted or forwarded.
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        m_rdata  = 64'hDEAD_BEEF_0000_0001;
        for (int c = 0; c < 3; c++) begin
            s_rready = 2'b11;
            #1;
            check_quiet("stray");
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = '0;

        // Both requesting from reset: 0,1,0,1, including an error response.
        do_reset();
        addr_m[0] = 24'h001000;
        len_m[0]  = 8'd2;
        addr_m[1] = 24'h002000;
        len_m[1]  = 8'd1;
        s_arvalid = 2'b11;
        for (int b = 0; b < 4; b++) begin
            do_burst(0, 1'b0, 1'b1, -1, (b == 1) ? 2'b10 : 2'b00);
        end

        // Address backpressure then read-ready toggling.
        do_burst(5, 1'b1, 1'b1, -1, 2'b00);

        // Single-beat bursts back to back.
        s_arvalid = '0;
        tick();
        len_m[0]  = 8'd0;
        len_m[1]  = 8'd0;
        s_arvalid = 2'b11;
        for (int b = 0; b < 4; b++) begin
            do_burst(0, 1'b0, 1'b1, 0, 2'b00);
        end

        // Asynchronous reset in the middle of a data burst.
        len_m[0] = 8'd3;
        len_m[1] = 8'd3;
        tick();
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rlast   = 1'b0;
        s_rready  = 2'b11;
        tick();
        chk("mid_burst_m_rready", m_rready, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_quiet("async_reset");
        #1;
        resetn   = 1'b1;
        m_rvalid = 1'b0;
        s_rready = '0;
        ptr_m    = 0;
        do_burst(0, 1'b0, 1'b1, -1, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
